// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with a two-entry skid (main + skid) and valid/ready handshakes.
// Latency: a word accepted while empty is on the outputs the next cycle.
// Backpressure: in_ready drops when both entries are full or when hit=0 freezes the stage.
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hit,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  readData1,
    input  logic [DATA_W-1:0]  readData2,
    input  logic [DATA_W-1:0]  immediate,
    input  logic [PC_W-1:0]    nextPC,
    input  logic [REG_W-1:0]   RT,
    input  logic [REG_W-1:0]   RD,
    input  logic [5:0]         Function,
    input  logic [ALUOP_W-1:0] ALUop,
    input  logic               destinationReg,
    input  logic               ALUsrc,
    input  logic               MemToReg,
    input  logic               RegWrite,
    input  logic               MEM_Read,
    input  logic               MEM_Write,
    input  logic               branch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  readData1_output,
    output logic [DATA_W-1:0]  readData2_output,
    output logic [DATA_W-1:0]  immediate_output,
    output logic [PC_W-1:0]    nextPC_output,
    output logic [REG_W-1:0]   RT_output,
    output logic [REG_W-1:0]   RD_output,
    output logic [5:0]         Function_output,
    output logic [ALUOP_W-1:0] ALUop_output,
    output logic               destinationReg_output,
    output logic               ALUsrc_output,
    output logic               MemToReg_output,
    output logic               RegWrite_output,
    output logic               MEM_Read_output,
    output logic               MEM_Write_output,
    output logic               branch_output,
    output logic               hit_output,
    output logic [1:0]         occupancy
);

    // ctrl bit order: {destinationReg, ALUsrc, MemToReg, RegWrite, MEM_Read, MEM_Write, branch}
    typedef struct packed {
        logic [DATA_W-1:0]  rd1;
        logic [DATA_W-1:0]  rd2;
        logic [DATA_W-1:0]  imm;
        logic [PC_W-1:0]    pc;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [5:0]         fn;
        logic [ALUOP_W-1:0] aluop;
        logic [6:0]         ctrl;
    } pay_t;

    pay_t in_pay;
    pay_t main_q, main_d;
    pay_t skid_q, skid_d;
    logic main_vld_q, main_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic hit_q;
    logic accept;
    logic pop;

    assign in_pay = {readData1, readData2, immediate, nextPC, RT, RD, Function, ALUop,
                     destinationReg, ALUsrc, MemToReg, RegWrite, MEM_Read, MEM_Write, branch};

    // skid is only ever valid behind a valid main, so occupancy is the sum of the two flags
    assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
    assign in_ready  = hit & ~skid_vld_q;
    assign accept    = in_valid & in_ready;
    assign pop       = main_vld_q & out_ready & hit;

    // Next-state for both entries: flush squashes, hit=0 freezes, otherwise shift in order
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (hit) begin
            unique case ({main_vld_q, skid_vld_q})
                2'b00: begin
                    if (accept) begin
                        main_d     = in_pay;
                        main_vld_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (accept && !pop) begin
                        skid_d     = in_pay;
                        skid_vld_d = 1'b1;
                    end else if (accept && pop) begin
                        main_d = in_pay;
                    end else if (pop) begin
                        main_vld_d = 1'b0;
                    end
                end
                2'b11: begin
                    if (pop) begin
                        main_d     = skid_q;
                        skid_vld_d = 1'b0;
                    end
                end
                default: begin
                    main_vld_d = 1'b0;
                    skid_vld_d = 1'b0;
                end
            endcase
        end
    end

    // State registers; reset clears everything, including the held payloads
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            hit_q      <= hit;
        end
    end

    assign out_valid             = main_vld_q;
    assign hit_output            = hit_q;
    assign readData1_output      = main_q.rd1;
    assign readData2_output      = main_q.rd2;
    assign immediate_output      = main_q.imm;
    assign nextPC_output         = main_q.pc;
    assign RT_output             = main_q.rt;
    assign RD_output             = main_q.rd;
    assign Function_output       = main_q.fn;
    assign ALUop_output          = main_q.aluop;
    assign destinationReg_output = main_q.ctrl[6];
    assign ALUsrc_output         = main_q.ctrl[5];
    assign MemToReg_output       = main_q.ctrl[4];
    // side-effecting controls are gated so an empty stage presents a bubble
    assign RegWrite_output       = main_q.ctrl[3] & main_vld_q;
    assign MEM_Read_output       = main_q.ctrl[2] & main_vld_q;
    assign MEM_Write_output      = main_q.ctrl[1] & main_vld_q;
    assign branch_output         = main_q.ctrl[0] & main_vld_q;

endmodule
